// File: rtl/dds_note_sequencer_if.sv
// Note request channel between the melody/score logic and the note sequencer.
// The score logic is the master; the sequencer is the slave.
interface dds_note_sequencer_if;
   logic        note_valid;
   logic        note_ready;
   logic [21:0] note_k;      // phase increment {12b int, 10b frac}
   logic [15:0] note_dur;    // length in ticks, 0 = discard

   modport master (output note_valid, output note_k, output note_dur, input note_ready);
   modport slave  (input note_valid, input note_k, input note_dur, output note_ready);
endinterface

// File: rtl/dds_note_sequencer.sv
// Note sequencer for the dds tone generator: one-deep note buffer, sampling
// pulse divider, duration counting in ticks of TICK_SAMPLES pulses, and
// gating of dds samples to silence between notes.
module dds_note_sequencer #(
   parameter int CLK_DIV      = 2083,
   parameter int TICK_SAMPLES = 48
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        play_en,
   dds_note_sequencer_if.slave         note,
   output logic                        sampling_pulse,
   output logic [21:0]                 k,
   input  logic                        dds_sample_ready,
   input  logic [15:0]                 dds_sample,
   output logic                        audio_valid,
   output logic [15:0]                 audio_sample,
   output logic                        note_done,
   output logic                        busy
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW = (TICK_SAMPLES > 1) ? $clog2(TICK_SAMPLES) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_SAMPLES - 1);

   typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

   state_t        state;
   logic [DW-1:0] divider;
   logic [CW-1:0] sample_cnt;
   logic [15:0]   rem;
   logic          pend_valid;
   logic [21:0]   pend_k;
   logic [15:0]   pend_dur;

   logic accept, tick, wrap, note_end, load;

   // Pulse is qualified by play_en so a pause parked on the last count
   // neither repeats nor drops the pulse.
   assign sampling_pulse  = play_en && (divider == DIV_LAST);
   assign accept          = note.note_valid && note.note_ready;
   assign tick            = (state == PLAY) && sampling_pulse;
   assign wrap            = tick && (sample_cnt == CNT_LAST);
   assign note_end        = wrap && (rem == 16'd1);
   // Pending note moves to the player when idle, or back-to-back at note end.
   assign load            = pend_valid && ((state == IDLE) || note_end);
   assign note.note_ready = !pend_valid;
   assign busy            = (state == PLAY) || pend_valid;

   // Free-running sample-rate divider, frozen while paused.
   always_ff @(posedge clk) begin
      if (!reset)
         divider <= '0;
      else if (play_en)
         divider <= (divider == DIV_LAST) ? '0 : divider + 1'b1;
   end

   // Pending buffer plus IDLE/PLAY player with duration counting.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         pend_valid <= 1'b0;
         pend_k     <= '0;
         pend_dur   <= '0;
         sample_cnt <= '0;
         rem        <= '0;
         k          <= '0;
         note_done  <= 1'b0;
      end else begin
         note_done <= 1'b0;

         // Zero-length requests are consumed but never buffered.
         if (load)
            pend_valid <= 1'b0;
         else if (accept && (note.note_dur != 16'd0)) begin
            pend_valid <= 1'b1;
            pend_k     <= note.note_k;
            pend_dur   <= note.note_dur;
         end

         case (state)
            IDLE: begin
               if (pend_valid) begin
                  k          <= pend_k;
                  rem        <= pend_dur;
                  sample_cnt <= '0;
                  state      <= PLAY;
               end
            end
            PLAY: begin
               if (wrap) begin
                  sample_cnt <= '0;
                  if (rem == 16'd1) begin
                     note_done <= 1'b1;
                     if (pend_valid) begin
                        k   <= pend_k;
                        rem <= pend_dur;
                     end else begin
                        k     <= '0;
                        rem   <= '0;
                        state <= IDLE;
                     end
                  end else
                     rem <= rem - 16'd1;
               end else if (tick)
                  sample_cnt <= sample_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Forward dds samples, muted when no note is playing.
   always_ff @(posedge clk) begin
      if (!reset) begin
         audio_valid  <= 1'b0;
         audio_sample <= '0;
      end else begin
         audio_valid <= dds_sample_ready;
         if (dds_sample_ready)
            audio_sample <= (state == PLAY) ? dds_sample : 16'd0;
      end
   end
endmodule

// File: tb/tb_dds_note_sequencer.sv
// Bench for dds_note_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a note-level reference model.
module tb_dds_note_sequencer;
   localparam int CD = 6;
   localparam int TS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        play_en = 1'b0;
   logic        dsr = 1'b0;
   logic [15:0] ds = '0;
   logic        sp, av, nd_o, busy;
   logic [21:0] k;
   logic [15:0] as;

   dds_note_sequencer_if nif();

   dds_note_sequencer #(.CLK_DIV(CD), .TICK_SAMPLES(TS)) dut (
      .clk(clk), .reset(rst_n), .play_en(play_en), .note(nif),
      .sampling_pulse(sp), .k(k), .dds_sample_ready(dsr), .dds_sample(ds),
      .audio_valid(av), .audio_sample(as), .note_done(nd_o), .busy(busy));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: enabled-cycle count for the pulse grid, notes tracked
   // as "pulses left to play".
   int          en_cnt = 0;
   bit          m_play = 0, m_pend = 0, m_done = 0, m_av = 0;
   logic [21:0] m_k = '0, m_pk = '0;
   int          m_left = 0, m_pdur = 0;
   logic [15:0] m_as = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit pulse, pre_play, pre_pend;
      if (!rst_n) begin
         en_cnt = 0; m_play = 0; m_pend = 0; m_done = 0; m_av = 0;
         m_k = '0; m_as = '0; m_left = 0;
         return;
      end
      pulse    = play_en && (en_cnt % CD == CD - 1);
      pre_play = m_play;
      pre_pend = m_pend;
      m_done   = 0;
      if (pre_play) begin
         if (pulse) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1;
               if (pre_pend) begin
                  m_k = m_pk; m_left = m_pdur * TS; m_pend = 0;
               end else
                  m_play = 0;
            end
         end
      end else if (pre_pend) begin
         m_play = 1; m_k = m_pk; m_left = m_pdur * TS; m_pend = 0;
      end
      if (nif.note_valid && !pre_pend && nif.note_dur != 0) begin
         m_pend = 1; m_pk = nif.note_k; m_pdur = int'(nif.note_dur);
      end
      m_av = dsr;
      if (dsr) m_as = pre_play ? ds : 16'd0;
      if (play_en) en_cnt++;
   endtask

   task automatic check_all();
      chk("k", k, m_play ? m_k : 22'd0);
      chk("sampling_pulse", sp, play_en && (en_cnt % CD == CD - 1));
      chk("note_ready", nif.note_ready, !m_pend);
      chk("busy", busy, m_play || m_pend);
      chk("note_done", nd_o, m_done);
      chk("audio_valid", av, m_av);
      chk("audio_sample", as, m_as);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic offer(input logic [21:0] nk, input logic [15:0] dur);
      nif.note_k = nk; nif.note_dur = dur; nif.note_valid = 1'b1;
      cyc();
      nif.note_valid = 1'b0;
   endtask

   initial begin
      int lat, pc, n;
      logic [21:0] ka, kb;
      ka = {12'd58, 10'd360};
      kb = {12'd98, 10'd68};
      nif.note_valid = 1'b0; nif.note_k = '0; nif.note_dur = '0;

      // 1: reset held for 3 clocks
      run(3);
      rst_n = 1'b1; play_en = 1'b1;
      cyc();
      chk("t1_ready", nif.note_ready, 1'b1);

      // 2: single note, latency and length
      offer(ka, 16'd2);
      lat = 1;
      while (k == 22'd0 && lat < 10) begin cyc(); lat++; end
      chk("t2_latency", lat, 2);
      pc = 0; n = 0;
      while (!nd_o && n < 100) begin if (sp) pc++; cyc(); n++; end
      chk("t2_done_seen", nd_o, 1'b1);
      chk("t2_pulses", pc, 8);
      cyc();
      chk("t2_idle_k", k, 22'd0);

      // 3: back-to-back A then B
      offer(ka, 16'd2);
      run(20);
      offer(kb, 16'd1);
      chk("t3_ready_low", nif.note_ready, 1'b0);
      n = 0;
      while (!nd_o && n < 100) begin cyc(); n++; end
      chk("t3_switch_k", k, kb);
      pc = 0; n = 0;
      cyc();
      while (!nd_o && n < 100) begin if (sp) pc++; cyc(); n++; end
      if (sp) pc++;
      chk("t3_b_pulses", pc, 4);
      chk("t3_end_k", k, 22'd0);

      // 4: pause mid-note
      offer(ka, 16'd2);
      run(15);
      play_en = 1'b0;
      pc = 0;
      for (int i = 0; i < 20; i++) begin cyc(); if (sp) pc++; end
      chk("t4_paused_pulses", pc, 0);
      play_en = 1'b1;
      n = 0;
      while (!nd_o && n < 100) begin cyc(); n++; end
      chk("t4_done_seen", nd_o, 1'b1);
      run(2);

      // 5: zero-length request is discarded
      offer(ka, 16'd0);
      run(5);
      chk("t5_busy", busy, 1'b0);
      chk("t5_k", k, 22'd0);

      // 6: audio gating and reset mid-note
      offer(kb, 16'd1);
      run(6);
      ds = 16'h1234; dsr = 1'b1;
      cyc();
      dsr = 1'b0;
      chk("t6_play_sample", as, 16'h1234);
      n = 0;
      while (!nd_o && n < 100) begin cyc(); n++; end
      run(2);
      dsr = 1'b1;
      cyc();
      dsr = 1'b0;
      chk("t6_idle_sample", as, 16'h0000);
      offer(ka, 16'd3);
      run(10);
      offer(kb, 16'd2);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("t6_rst_k", k, 22'd0);
      chk("t6_rst_busy", busy, 1'b0);
      run(60);

      // Random traffic
      for (int i = 0; i < 2500; i++) begin
         nif.note_valid = ($urandom_range(0, 3) == 0);
         nif.note_k     = 22'($urandom);
         nif.note_dur   = 16'($urandom_range(0, 3));
         play_en        = ($urandom_range(0, 9) != 0);
         dsr            = ($urandom_range(0, 4) == 0);
         ds             = 16'($urandom);
         rst_n          = ($urandom_range(0, 399) != 0);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
